// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer: clear the back buffer, run the line jobs, swap buffers on vsync.
// Also owns the single framebuffer write port, muxing clear and line pixels into one registered stream.
module frame_draw_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int IDX_W   = 8,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 19
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               vsync_pulse,
  input  logic [IDX_W-1:0]   line_count,
  output logic               clear_start,
  input  logic               clear_done,
  input  logic [9:0]         clear_x,
  input  logic [9:0]         clear_y,
  output logic               line_start,
  output logic [IDX_W-1:0]   line_idx,
  input  logic               line_done,
  input  logic               line_plot,
  input  logic [9:0]         line_x,
  input  logic [9:0]         line_y,
  input  logic [COLOR_W-1:0] line_color,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_sel,
  output logic               display_buf,
  output logic               frame_done,
  output logic               busy
);

  // A visible frame must fit inside one buffer's address space.
  if (H_RES * V_RES > (1 << ADDR_W)) begin : g_bad_geometry
    $error("frame_draw_scheduler: H_RES*V_RES exceeds 2**ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CLEAR_REL,
    LINE,
    LINE_REL,
    FLIP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;

  logic               vld_p0;
  logic [9:0]         x_p0;
  logic [9:0]         y_p0;
  logic [COLOR_W-1:0] data_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [COLOR_W-1:0] data_p1;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));
  endfunction

  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      clear_start <= 1'b0;
      line_start  <= 1'b0;
      line_idx    <= '0;
      display_buf <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && vsync_pulse) begin
            state       <= CLEAR;
            cnt         <= line_count;
            idx         <= '0;
            clear_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_done) begin
            state       <= CLEAR_REL;
            clear_start <= 1'b0;
          end
        end
        CLEAR_REL: begin
          // Wait for the clear engine to drop done before handing over to the line engine.
          if (!clear_done) begin
            idx <= '0;
            if (cnt == '0) begin
              state <= FLIP;
            end else begin
              state      <= LINE;
              line_start <= 1'b1;
              line_idx   <= '0;
            end
          end
        end
        LINE: begin
          if (line_done) begin
            state      <= LINE_REL;
            line_start <= 1'b0;
          end
        end
        LINE_REL: begin
          if (!line_done) begin
            if (idx_nxt == cnt) begin
              state <= FLIP;
            end else begin
              state      <= LINE;
              idx        <= idx_nxt;
              line_idx   <= idx_nxt;
              line_start <= 1'b1;
            end
          end
        end
        FLIP: begin
          // Swap only on vsync; an overrunning frame just lands on a later one.
          if (vsync_pulse) begin
            display_buf <= ~display_buf;
            frame_done  <= 1'b1;
            if (enable) begin
              state       <= CLEAR;
              cnt         <= line_count;
              idx         <= '0;
              clear_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          clear_start <= 1'b0;
          line_start  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: select the pixel source for this cycle.
  always_comb begin
    vld_p0  = 1'b0;
    x_p0    = line_x;
    y_p0    = line_y;
    data_p0 = line_color;
    if (state == CLEAR && !clear_done) begin
      vld_p0  = 1'b1;
      x_p0    = clear_x;
      y_p0    = clear_y;
      data_p0 = '0;
    end else if (state == LINE && line_plot) begin
      vld_p0 = 1'b1;
    end
  end

  // Stage p1: registered framebuffer write; address/data hold while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= pix_addr(x_p0, y_p0);
        data_p1 <= data_p0;
      end
    end
  end

  assign fb_we   = vld_p1;
  assign fb_addr = addr_p1;
  assign fb_data = data_p1;
  assign fb_sel  = ~display_buf;

endmodule
